// File: rtl/uart_tx_bridge_if.sv
// Byte-stream handshake between the core and the UART transmitter.
// The core drives valid/bits as master; the transmitter returns ready as slave.
interface uart_tx_bridge_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  valid;
  logic                  ready;
  logic [DATA_WIDTH-1:0] bits;

  modport master (output valid, output bits, input ready);
  modport slave  (input valid, input bits, output ready);
endinterface

// File: rtl/uart_tx_bridge.sv
// uart_tx_bridge: device-side UART transmitter.
// Accepts bytes over a ready/valid stream into a small FIFO and serializes each
// one as start, 8 data bits LSB first, optional parity, then 1 or 2 stop bits.
// Optional feature macro: UART_TX_PARITY_EN adds the parity_odd input and a
// parity bit after the data bits. Without it frames carry no parity.
module uart_tx_bridge #(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int DIV_WIDTH  = 16
) (
  input  logic                          clock,
  input  logic                          reset,
  uart_tx_bridge_if.slave               stream,
  input  logic [DIV_WIDTH-1:0]          divisor,
  input  logic                          nstop,
`ifdef UART_TX_PARITY_EN
  input  logic                          parity_odd,
`endif
  output logic                          txd,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int           AW   = $clog2(FIFO_DEPTH);
  localparam logic [AW:0]  FULL = (AW+1)'(FIFO_DEPTH);

  // Per-frame settings, captured when a byte leaves the FIFO so that
  // changes on the inputs only affect the next frame.
  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic [DIV_WIDTH-1:0]  div;
    logic                  nstop;
`ifdef UART_TX_PARITY_EN
    logic                  par_odd;
`endif
  } frame_t;

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

  // FIFO storage
  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]         wr_ptr, rd_ptr;
  logic [AW:0]           count;
  logic                  push, pop;

  // Serializer state
  state_t                state;
  frame_t                cfg, next_cfg;
  logic [DIV_WIDTH-1:0]  cnt;
  logic [2:0]            idx;
  logic [2:0]            idx_next;
  logic                  stop_idx;
  logic                  bit_end;
  logic                  last_stop;

  // Ready depends only on occupancy, so a same-cycle pop never opens the gate.
  assign stream.ready = !reset && (count != FULL);
  assign push         = stream.valid && stream.ready;

  assign bit_end   = (cnt == '0);
  assign last_stop = (state == STOP) && bit_end && (stop_idx == cfg.nstop);
  assign pop       = !reset && (count != '0) && ((state == IDLE) || last_stop);
  assign idx_next  = idx + 3'd1;

  assign next_cfg.data  = mem[rd_ptr];
  assign next_cfg.div   = divisor;
  assign next_cfg.nstop = nstop;
`ifdef UART_TX_PARITY_EN
  assign next_cfg.par_odd = parity_odd;
`endif

  assign busy       = (state != IDLE) || (count != '0);
  assign fifo_count = count;

  // FIFO pointers and occupancy; pointers wrap naturally at FIFO_DEPTH.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  // FIFO data array, written on accepted pushes.
  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= stream.bits;
  end

  // Frame sequencer: every bit holds txd for cfg.div+1 clocks via a reloaded
  // down-counter; a pending byte at the end of the last stop bit starts the
  // next frame with no idle gap.
  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      txd      <= 1'b1;
      cfg      <= '0;
      cnt      <= '0;
      idx      <= '0;
      stop_idx <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          txd <= 1'b1;
          if (pop) begin
            cfg   <= next_cfg;
            cnt   <= divisor;
            state <= START;
            txd   <= 1'b0;
          end
        end

        START: begin
          if (bit_end) begin
            cnt   <= cfg.div;
            idx   <= '0;
            state <= DATA;
            txd   <= cfg.data[0];
          end else begin
            cnt <= cnt - 1'b1;
          end
        end

        DATA: begin
          if (bit_end) begin
            cnt <= cfg.div;
            if (idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
              state <= PARITY;
              txd   <= (^cfg.data) ^ cfg.par_odd;
`else
              state    <= STOP;
              stop_idx <= 1'b0;
              txd      <= 1'b1;
`endif
            end else begin
              idx <= idx_next;
              txd <= cfg.data[idx_next];
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end

`ifdef UART_TX_PARITY_EN
        PARITY: begin
          if (bit_end) begin
            cnt      <= cfg.div;
            stop_idx <= 1'b0;
            state    <= STOP;
            txd      <= 1'b1;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
`endif

        STOP: begin
          txd <= 1'b1;
          if (bit_end) begin
            if (stop_idx != cfg.nstop) begin
              // second stop bit
              stop_idx <= 1'b1;
              cnt      <= cfg.div;
            end else if (pop) begin
              cfg   <= next_cfg;
              cnt   <= divisor;
              state <= START;
              txd   <= 1'b0;
            end else begin
              state <= IDLE;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end

        default: begin
          state <= IDLE;
          txd   <= 1'b1;
        end
      endcase
    end
  end

endmodule
